// File: rtl/mem_io_responder.sv
// Responder for the CPU byte bus: synchronous byte RAM plus an I/O window for the UART and the cycle counter.
// RAM contents are loaded externally by the host path.
module mem_io_responder #(
  parameter int    ADDR_WIDTH  = 17,
  parameter int    TX_FIFO_LOG = 3,
  parameter string INIT_FILE   = "test.data"
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        program_done,
  output logic        tx_overflow
);

  localparam int              DEPTH   = 1 << TX_FIFO_LOG;
  localparam int              CW      = TX_FIFO_LOG + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [18:0]     RAM_TOP = 19'(1) << ADDR_WIDTH;

  logic [7:0] ram [0:(1<<ADDR_WIDTH)-1];
  logic [7:0] fifo [0:DEPTH-1];

  localparam string unused_init_file = INIT_FILE;

  logic unused_addr_hi;
  assign unused_addr_hi = ^mem_a[31:18];

  logic [17:0]           a18;
  logic                  io_hit, ram_hit, ram_we;
  logic [2:0]            io_sel;
  logic [ADDR_WIDTH-1:0] ram_idx;

  logic                   sel_ram_d, sel_ram_q;
  logic [7:0]             io_din_d, io_din_q;
  logic [7:0]             ram_rd_q;
  logic [31:0]            cnt_d, cnt_q;
  logic [31:0]            latch_d, latch_q;
  logic [TX_FIFO_LOG-1:0] head_d, head_q, tail_d, tail_q;
  logic [CW-1:0]          count_d, count_q;
  logic                   ovf_d, ovf_q, done_d, done_q;
  logic                   push_req, push_ok, pop, full;
  logic [7:0]             push_byte;

  always_comb begin
    a18     = mem_a[17:0];
    io_hit  = (a18[17:16] == 2'b11);
    ram_hit = !io_hit && ({1'b0, a18} < RAM_TOP);
    ram_we  = ram_hit && mem_wr;
    io_sel  = a18[2:0];
    ram_idx = mem_a[ADDR_WIDTH-1:0];
  end

  // Read-data select: the RAM path keeps its own output register so it maps to block RAM.
  always_comb begin
    sel_ram_d = ram_hit;
    io_din_d  = 8'h00;
    latch_d   = latch_q;
    cnt_d     = cnt_q + 32'd1;
    if (io_hit && !mem_wr) begin
      case (io_sel)
        3'd0: io_din_d = rx_valid ? rx_data : 8'h00;
        3'd4: begin
          latch_d  = cnt_q;
          io_din_d = cnt_q[7:0];
        end
        3'd5: io_din_d = latch_q[15:8];
        3'd6: io_din_d = latch_q[23:16];
        3'd7: io_din_d = latch_q[31:24];
        default: io_din_d = 8'h00;
      endcase
    end
  end

  always_comb begin
    push_req  = io_hit && mem_wr &&
                (((io_sel == 3'd0) && (mem_dout != 8'h00)) || (io_sel == 3'd4));
    push_byte = (io_sel == 3'd4) ? 8'h00 : mem_dout;
    full      = (count_q == DEPTH_C);
    pop       = tx_valid && tx_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    push_ok   = push_req && (!full || pop);
    head_d    = pop ? head_q + 1'b1 : head_q;
    tail_d    = push_ok ? tail_q + 1'b1 : tail_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ovf_d  = ovf_q || (push_req && !push_ok);
    done_d = done_q || (io_hit && mem_wr && (io_sel == 3'd4));
  end

  always_ff @(posedge clk_in) begin
    if (ram_we) ram[ram_idx] <= mem_dout;
    ram_rd_q <= ram[ram_idx];
    if (push_ok) fifo[tail_q] <= push_byte;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sel_ram_q <= 1'b0;
      io_din_q  <= 8'h00;
      cnt_q     <= 32'd0;
      latch_q   <= 32'd0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      sel_ram_q <= sel_ram_d;
      io_din_q  <= io_din_d;
      cnt_q     <= cnt_d;
      latch_q   <= latch_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    mem_din        = sel_ram_q ? ram_rd_q : io_din_q;
    io_buffer_full = (count_q >= DEPTH_C - 1'b1);
    tx_data        = fifo[head_q];
    tx_valid       = (count_q != '0);
    rx_pop         = !rst_in && io_hit && !mem_wr && (io_sel == 3'd0) && rx_valid;
    program_done   = done_q;
    tx_overflow    = ovf_q;
  end

endmodule
